// File: rtl/jtgng_snd_i2s_pkg.sv
// Shared constants and the gain multiply for the jtgng I2S audio output stage.
package jtgng_snd_i2s_pkg;

    localparam int FRAME_BITS = 32;
    localparam int GAIN_ONE   = 256;
    localparam int GAIN_W     = 9;
    localparam int SLOT_W     = 5;
    localparam int SAMPLE_W   = 16;
    localparam int PROD_W     = SAMPLE_W + GAIN_W + 1;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [GAIN_W-1:0]          gain_t;

    // Gain is unsigned 0..256, so it is zero-extended before the signed multiply;
    // the arithmetic shift floors toward minus infinity and the result always fits 16 bits.
    function automatic sample_t applyGain(input sample_t s, input gain_t g);
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(s) * PROD_W'($signed({1'b0, g}));
        return SAMPLE_W'(prod >>> 8);
    endfunction

endpackage

// File: rtl/jtgng_i2s_ser.sv
// I2S serialiser: derives bclk/lrck from clk by counting and shifts out a 32-bit frame word.
module jtgng_i2s_ser
    import jtgng_snd_i2s_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] word_i,
    output logic                  load_o,
    output logic                  bclk_o,
    output logic                  lrck_o,
    output logic                  sdata_o,
    output logic                  frame_o
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_BITS - 1);

    logic [DIV_W-1:0]      divCnt_q, divCnt_d;
    logic [SLOT_W-1:0]     bitCnt_q, bitCnt_d;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  bclk_q, lrck_q, sdata_q, frame_q, started_q;
    logic                  wrap, fallEv;

    assign wrap     = (divCnt_q == DIV_LAST);
    assign fallEv   = wrap & bclk_q;
    assign divCnt_d = wrap ? '0 : divCnt_q + DIV_W'(1);
    assign bitCnt_d = bitCnt_q + SLOT_W'(1);
    assign load_o   = fallEv & started_q & (bitCnt_q == SLOT_LAST);

    // The first falling event after reset only enters slot 0; later ones advance the slot.
    // Slot k outputs shift_q[31] after k-1 shifts, so slot 0 still carries the old frame's LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt_q  <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            bclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
            sdata_q   <= 1'b0;
            frame_q   <= 1'b0;
            started_q <= 1'b0;
        end else begin
            divCnt_q <= divCnt_d;
            frame_q  <= load_o;
            if (wrap) begin
                bclk_q <= ~bclk_q;
            end
            if (fallEv) begin
                if (!started_q) begin
                    started_q <= 1'b1;
                    lrck_q    <= 1'b0;
                    sdata_q   <= 1'b0;
                end else begin
                    bitCnt_q <= bitCnt_d;
                    lrck_q   <= bitCnt_d[SLOT_W-1];
                    sdata_q  <= shift_q[FRAME_BITS-1];
                    shift_q  <= load_o ? word_i : {shift_q[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign bclk_o  = bclk_q;
    assign lrck_o  = lrck_q;
    assign sdata_o = sdata_q;
    assign frame_o = frame_q;

endmodule

// File: rtl/jtgng_snd_i2s.sv
// Audio output stage: sample capture, soft-mute gain ramp and mono-duplicated I2S output.
module jtgng_snd_i2s
    import jtgng_snd_i2s_pkg::*;
#(
    parameter int unsigned BCLK_DIV  = 4,
    parameter int unsigned RAMP_STEP = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SAMPLE_W-1:0] snd_in,
    input  logic                       sample,
    input  logic                       mute,
    output logic                       bclk,
    output logic                       lrck,
    output logic                       sdata,
    output logic                       frame,
    output logic                       muted
);

    localparam logic [GAIN_W:0] STEP  = (GAIN_W + 1)'(RAMP_STEP);
    localparam logic [GAIN_W:0] ONE_X = (GAIN_W + 1)'(GAIN_ONE);

    logic            sampleDly_q;
    sample_t         hold_q, scaled;
    gain_t           gain_q, gain_d;
    logic            muted_q;
    logic            loadEv;
    logic [GAIN_W:0] gainExt, gainUp;

    assign scaled  = applyGain(hold_q, gain_q);
    assign gainExt = {1'b0, gain_q};
    assign gainUp  = gainExt + STEP;

    // Saturating ramp, computed one bit wider so neither end can wrap.
    always_comb begin
        gain_d = gain_q;
        if (mute) begin
            gain_d = (gainExt > STEP) ? GAIN_W'(gainExt - STEP) : '0;
        end else begin
            gain_d = (gainUp > ONE_X) ? GAIN_W'(ONE_X) : GAIN_W'(gainUp);
        end
    end

    // The frame word is built from the gain before this load's update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sampleDly_q <= 1'b0;
            hold_q      <= '0;
            gain_q      <= '0;
            muted_q     <= 1'b1;
        end else begin
            sampleDly_q <= sample;
            if (sample && !sampleDly_q) begin
                hold_q <= snd_in;
            end
            if (loadEv) begin
                gain_q  <= gain_d;
                muted_q <= (gain_d == '0);
            end
        end
    end

    jtgng_i2s_ser #(
        .BCLK_DIV (BCLK_DIV)
    ) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .word_i  ({scaled, scaled}),
        .load_o  (loadEv),
        .bclk_o  (bclk),
        .lrck_o  (lrck),
        .sdata_o (sdata),
        .frame_o (frame)
    );

    assign muted = muted_q;

endmodule
